// File: rtl/mic_pkg.sv
// mic_pkg: shared widths and types for the mic energy and direction-calculation path
package mic_pkg;
   localparam int MIC_ENERGY_WIDTH = 32;
   localparam int NUM_PERIPH_MICS = 3;
   localparam int MIC_SAMPLE_WIDTH = 16;
   typedef logic signed [MIC_SAMPLE_WIDTH-1:0] mic_sample_t;
   typedef logic [MIC_ENERGY_WIDTH-1:0] mic_energy_t;
endpackage

// File: rtl/mic_channel_accumulator.sv
// mic_channel_accumulator: per-mic magnitude stage, optional DC tracker (MIC_ENERGY_DC_REMOVE_EN) and window accumulator
module mic_channel_accumulator
   import mic_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           take,
   input  logic                           clear,
   input  logic                           add,
   input  logic                           wrap,
   input  logic signed [SAMPLE_WIDTH-1:0] sample,
   output mic_energy_t                    total
);
   localparam int SW = SAMPLE_WIDTH;
   logic [SW:0] mag;
   logic [SW:0] mag_next;
   mic_energy_t acc;
   mic_energy_t sum;
`ifdef MIC_ENERGY_DC_REMOVE_EN
   logic signed [SW+7:0] dc;
   logic signed [SW+8:0] dc_err;
   logic signed [SW+1:0] centred;
   logic [SW+1:0] centred_abs;
   assign dc_err = {sample[SW-1], sample, 8'd0} - {dc[SW+7], dc};
   assign centred = {{2{sample[SW-1]}}, sample} - {{2{dc[SW+7]}}, dc[SW+7:8]};
   assign centred_abs = centred[SW+1] ? -centred : centred;
   assign mag_next = centred_abs[SW+1] ? '1 : centred_abs[SW:0];
   // slow first-order DC estimate, survives clear so the level stays tracked
   always_ff @(posedge clk)
      if (!rst_n) dc <= '0;
      else if (take) dc <= dc + (SW+8)'(dc_err >>> 8);
`else
   logic [SW:0] ext;
   assign ext = {sample[SW-1], sample};
   assign mag_next = ext[SW] ? -ext : ext;
`endif
   assign sum = acc + MIC_ENERGY_WIDTH'(mag);
   // stage 1: magnitude one bit wider than the sample so the most negative value cannot wrap
   always_ff @(posedge clk)
      if (!rst_n) mag <= '0;
      else if (take) mag <= mag_next;
   // stage 2: accumulate, restarting from zero as the window closes
   always_ff @(posedge clk)
      if (!rst_n || clear) acc <= '0;
      else if (add) acc <= wrap ? '0 : sum;
   // capture the finished window total including the closing sample
   always_ff @(posedge clk)
      if (!rst_n) total <= '0;
      else if (add && wrap) total <= sum;
endmodule

// File: rtl/mic_energy_accumulator.sv
// mic_energy_accumulator: windowed absolute-amplitude energy per mic; DC removal via MIC_ENERGY_DC_REMOVE_EN
module mic_energy_accumulator
   import mic_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int NUM_PERIPH   = 3,
   parameter int WINDOW_LOG2  = 10
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic                           sample_valid_in,
   input  logic signed [SAMPLE_WIDTH-1:0] central_sample_in,
   input  logic signed [SAMPLE_WIDTH-1:0] periph_samples_in [NUM_PERIPH],
   input  logic                           clear_in,
   output mic_energy_t                    central_mic_out,
   output mic_energy_t                    peripheral_mics_out [NUM_PERIPH],
   output logic                           energy_valid_out
);
   if (SAMPLE_WIDTH + 1 + WINDOW_LOG2 > 32) begin : g_width_check
      $error("SAMPLE_WIDTH+1+WINDOW_LOG2 exceeds the 32-bit energy width");
   end
   logic take;
   logic v1;
   logic add;
   logic wrap;
   logic done;
   logic [WINDOW_LOG2-1:0] cnt;
   logic signed [SAMPLE_WIDTH-1:0] samples [NUM_PERIPH+1];
   mic_energy_t totals [NUM_PERIPH+1];
   assign take = sample_valid_in && !clear_in;
   assign add = v1 && !clear_in;
   assign wrap = &cnt;
   assign samples[0] = central_sample_in;
   for (genvar g = 0; g < NUM_PERIPH; g++) begin : g_map
      assign samples[g+1] = periph_samples_in[g];
   end
   for (genvar g = 0; g <= NUM_PERIPH; g++) begin : g_ch
      mic_channel_accumulator #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_ch (
         .clk    (clk_in),
         .rst_n  (rst_n_in),
         .take   (take),
         .clear  (clear_in),
         .add    (add),
         .wrap   (wrap),
         .sample (samples[g]),
         .total  (totals[g])
      );
   end
   // stage-1 valid and window position; clear abandons the window in flight
   always_ff @(posedge clk_in)
      if (!rst_n_in || clear_in) begin
         v1  <= 1'b0;
         cnt <= '0;
      end else begin
         v1 <= sample_valid_in;
         if (v1) cnt <= cnt + WINDOW_LOG2'(1);
      end
   // window-complete flag, one cycle behind the closing accumulation
   always_ff @(posedge clk_in)
      if (!rst_n_in) done <= 1'b0;
      else done <= add && wrap;
   // publish finished totals with a single-cycle strobe; hold otherwise
   always_ff @(posedge clk_in)
      if (!rst_n_in) begin
         central_mic_out  <= '0;
         energy_valid_out <= 1'b0;
         for (int i = 0; i < NUM_PERIPH; i++) peripheral_mics_out[i] <= '0;
      end else begin
         energy_valid_out <= done;
         if (done) begin
            central_mic_out <= totals[0];
            for (int i = 0; i < NUM_PERIPH; i++) peripheral_mics_out[i] <= totals[i+1];
         end
      end
endmodule

// File: tb/tb_mic_energy_accumulator.sv
// tb_mic_energy_accumulator: scoreboard bench for mic_energy_accumulator with a 4-sample window
module tb_mic_energy_accumulator;
   import mic_pkg::*;
   localparam int SW = 16;
   localparam int NP = 3;
   localparam int WL = 2;
   typedef struct {
      int          at;
      mic_energy_t c;
      mic_energy_t p [NP];
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sv = 1'b0;
   logic clr = 1'b0;
   logic signed [SW-1:0] cs = '0;
   logic signed [SW-1:0] ps [NP];
   mic_energy_t cen;
   mic_energy_t per [NP];
   logic ev;
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   exp_t q [$];
   exp_t mon_e;

   mic_energy_accumulator #(.SAMPLE_WIDTH(SW), .NUM_PERIPH(NP), .WINDOW_LOG2(WL)) dut (
      .clk_in              (clk),
      .rst_n_in            (rst_n),
      .sample_valid_in     (sv),
      .central_sample_in   (cs),
      .periph_samples_in   (ps),
      .clear_in            (clr),
      .central_mic_out     (cen),
      .peripheral_mics_out (per),
      .energy_valid_out    (ev)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // monitor: every strobe must match the oldest expected window, on its cycle
   always @(negedge clk)
      if (ev) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe: energy_valid_out=1 at cycle %0d, expected 0", cyc);
         end else begin
            mon_e = q.pop_front();
            chk("strobe_cycle", cyc, mon_e.at);
            chk("central", cen, mon_e.c);
            for (int i = 0; i < NP; i++) chk($sformatf("periph%0d", i), per[i], mon_e.p[i]);
         end
      end

   task automatic step(input logic v, input logic c, input logic signed [SW-1:0] cv,
                       input logic signed [SW-1:0] p0, input logic signed [SW-1:0] p1,
                       input logic signed [SW-1:0] p2);
      sv = v; clr = c; cs = cv; ps[0] = p0; ps[1] = p1; ps[2] = p2;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic smp(input logic signed [SW-1:0] cv, input logic signed [SW-1:0] pv);
      step(1'b1, 1'b0, cv, pv, pv, pv);
   endtask

   task automatic expect_win(input mic_energy_t c, input mic_energy_t p0,
                             input mic_energy_t p1, input mic_energy_t p2);
      exp_t e;
      e.at = cyc + 2; e.c = c; e.p[0] = p0; e.p[1] = p1; e.p[2] = p2;
      q.push_back(e);
   endtask

   initial begin
      ps[0] = '0; ps[1] = '0; ps[2] = '0;
      @(negedge clk);
      idle(3);
      chk("rst_central", cen, 32'h0);
      chk("rst_periph0", per[0], 32'h0);
      chk("rst_valid", {31'd0, ev}, 32'h0);
      rst_n = 1'b1;
      idle(2);
      // opposite-sign equal magnitudes
      repeat (4) smp(16'sh1000, -16'sh1000);
      expect_win(32'h4000, 32'h4000, 32'h4000, 32'h4000);
      idle(4);
      // most negative sample must not wrap
      repeat (4) smp(16'sh8000, 16'sh8000);
      expect_win(32'h20000, 32'h20000, 32'h20000, 32'h20000);
      idle(4);
      // distinct per-channel values catch channel mix-ups
      repeat (4) step(1'b1, 1'b0, 16'sd2, 16'sd1, -16'sd4, 16'sd100);
      expect_win(32'd8, 32'd4, 32'd16, 32'd400);
      idle(4);
      // back-to-back windows: strobes 4 cycles apart, clean restart
      repeat (4) smp(16'sd1, 16'sd1);
      expect_win(32'd4, 32'd4, 32'd4, 32'd4);
      repeat (4) smp(16'sd3, 16'sd3);
      expect_win(32'd12, 32'd12, 32'd12, 32'd12);
      idle(4);
      // clear on the 4th sample: window dropped, outputs held
      repeat (3) smp(16'sh100, 16'sh100);
      step(1'b1, 1'b1, 16'sh100, 16'sh100, 16'sh100, 16'sh100);
      idle(4);
      chk("clear_hold_central", cen, 32'd12);
      chk("clear_hold_periph2", per[2], 32'd12);
      repeat (4) smp(16'sh100, 16'sh100);
      expect_win(32'h400, 32'h400, 32'h400, 32'h400);
      idle(4);
      // clear on the completion edge wins over the strobe
      repeat (4) smp(16'sd7, 16'sd7);
      step(1'b0, 1'b1, '0, '0, '0, '0);
      idle(4);
      chk("clear_win_central", cen, 32'h400);
      repeat (4) smp(16'sd7, -16'sd7);
      expect_win(32'd28, 32'd28, 32'd28, 32'd28);
      idle(4);
      // reset mid-window discards the partial window
      repeat (2) smp(16'sd9, 16'sd9);
      rst_n = 1'b0;
      idle(2);
      chk("midrst_central", cen, 32'h0);
      chk("midrst_periph1", per[1], 32'h0);
      chk("midrst_valid", {31'd0, ev}, 32'h0);
      rst_n = 1'b1;
      // gaps of 1, 2 and 3 idle cycles between samples
      smp(16'sd5, 16'sd5);
      idle(1);
      smp(16'sd5, 16'sd5);
      idle(2);
      smp(16'sd5, 16'sd5);
      idle(3);
      smp(16'sd5, 16'sd5);
      expect_win(32'd20, 32'd20, 32'd20, 32'd20);
      idle(4);
      repeat (4) smp(-16'sd5, 16'sd5);
      expect_win(32'd20, 32'd20, 32'd20, 32'd20);
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      idle(3);
      chk("queue_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
